// File: rtl/cbus_req_arbiter.sv
// Two-master (ibus/dbus) request arbiter in front of the MMU virtual port.
// Holds one grant per transaction and inserts a one-cycle drain gap after each response.
package cbus_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

module cbus_req_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  input  cbus_req_t  dreq,
  output cbus_resp_t dresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_cnt_nxt;
  logic             r_ivalid;
  logic             r_dvalid;
  logic             w_done;

  // State, starvation counter and the sampled request valids used by the IDLE decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_ivalid     <= 1'b0;
      r_dvalid     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_ivalid     <= ireq.valid;
      r_dvalid     <= dreq.valid;
    end
  end

  assign w_done = oresp.ready && oresp.last;

  // Next-state decision and combinational request/response routing
  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;
    oreq             = '0;
    iresp            = '0;
    dresp            = '0;
    case (r_state)
      S_IDLE: begin
        if (!r_ivalid) begin
          w_starve_cnt_nxt = '0;
        end
        // The dbus branch is only taken with ibus pending while below LIMIT, so +1 saturates.
        if (r_dvalid && (!r_ivalid || (r_starve_cnt < LIMIT))) begin
          w_state_nxt = S_GRANT_D;
          if (r_ivalid) begin
            w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
          end
        end else if (r_ivalid) begin
          w_state_nxt      = S_GRANT_I;
          w_starve_cnt_nxt = '0;
        end
      end
      S_GRANT_I: begin
        oreq  = ireq;
        iresp = oresp;
        if (w_done) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_GRANT_D: begin
        oreq  = dreq;
        dresp = oresp;
        if (w_done) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (rst) begin
      oreq  = '0;
      iresp = '0;
      dresp = '0;
    end
  end

endmodule
